// File: rtl/hazard_flush_ctrl.sv
// Central pipeline sequencer for the 5-stage core: load-use interlock, branch flush,
// data-memory wait freeze, and ecall drain/halt, driving all pipeline stall/flush controls.
module hazard_flush_ctrl #(
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned MEM_TIMEOUT  = 64,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1_index,
  input  logic [4:0]       id_rs2_index,
  input  logic             id_rs2_used,
  input  logic [4:0]       ex_rd_index,
  input  logic             ex_wb_en,
  input  logic             ex_wb_sel,
  input  logic             ex_branch_taken,
  input  logic             mem_ecall_sig,
  input  logic             mem_dm_req,
  input  logic             mem_dm_ready,
  output logic             pc_stall,
  output logic             fd_stall,
  output logic             fd_flush,
  output logic             de_stall,
  output logic             de_flush,
  output logic             em_stall,
  output logic             em_flush,
  output logic             mw_flush,
  output logic             halt,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_MEM_WAIT,
    ST_DRAIN,
    ST_HALT
  } state_e;

  localparam logic [3:0]       DRAIN_LAST = 4'(DRAIN_CYCLES - 1);
  localparam logic [7:0]       WAIT_LIMIT = 8'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_e           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic [3:0]       drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             halt_q, halt_d;
  logic             mem_err_q, mem_err_d;

  logic load_use;
  logic dm_wait;
  logic pc_stall_c, fd_stall_c, fd_flush_c, de_stall_c;
  logic de_flush_c, em_stall_c, em_flush_c, mw_flush_c;

  always_comb begin
    load_use = ex_wb_en && ex_wb_sel && (ex_rd_index != 5'd0) &&
               ((ex_rd_index == id_rs1_index) ||
                (id_rs2_used && (ex_rd_index == id_rs2_index)));
    dm_wait  = mem_dm_req && !mem_dm_ready;
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    drain_cnt_d = drain_cnt_q;
    halt_d      = halt_q;
    mem_err_d   = mem_err_q;
    pc_stall_c  = 1'b0;
    fd_stall_c  = 1'b0;
    fd_flush_c  = 1'b0;
    de_stall_c  = 1'b0;
    de_flush_c  = 1'b0;
    em_stall_c  = 1'b0;
    em_flush_c  = 1'b0;
    mw_flush_c  = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (mem_ecall_sig) begin
          pc_stall_c  = 1'b1;
          fd_flush_c  = 1'b1;
          de_flush_c  = 1'b1;
          em_flush_c  = 1'b1;
          state_d     = ST_DRAIN;
          drain_cnt_d = '0;
        end else if (dm_wait) begin
          pc_stall_c = 1'b1;
          fd_stall_c = 1'b1;
          de_stall_c = 1'b1;
          em_stall_c = 1'b1;
          mw_flush_c = 1'b1;
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = 8'd1;
        end else if (ex_branch_taken) begin
          // PC loads the branch target, so no PC stall; this also overrides load-use.
          fd_flush_c = 1'b1;
          de_flush_c = 1'b1;
        end else if (load_use) begin
          pc_stall_c = 1'b1;
          fd_stall_c = 1'b1;
          de_flush_c = 1'b1;
        end
      end

      ST_MEM_WAIT: begin
        // Branch/load-use are ignored here; the frozen pipe re-presents them in RUN.
        if (mem_dm_ready) begin
          state_d = ST_RUN;
        end else begin
          pc_stall_c = 1'b1;
          fd_stall_c = 1'b1;
          de_stall_c = 1'b1;
          em_stall_c = 1'b1;
          mw_flush_c = 1'b1;
          if (wait_cnt_q == WAIT_LIMIT) begin
            state_d   = ST_HALT;
            halt_d    = 1'b1;
            mem_err_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end
      end

      ST_DRAIN: begin
        pc_stall_c = 1'b1;
        fd_flush_c = 1'b1;
        de_flush_c = 1'b1;
        em_flush_c = 1'b1;
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d = ST_HALT;
          halt_d  = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q + 4'd1;
        end
      end

      ST_HALT: begin
        pc_stall_c = 1'b1;
        fd_flush_c = 1'b1;
        de_flush_c = 1'b1;
        em_flush_c = 1'b1;
        mw_flush_c = 1'b1;
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_comb begin
    pc_stall = rst && pc_stall_c;
    fd_stall = rst && fd_stall_c;
    fd_flush = rst && fd_flush_c;
    de_stall = rst && de_stall_c;
    de_flush = rst && de_flush_c;
    em_stall = rst && em_stall_c;
    em_flush = rst && em_flush_c;
    mw_flush = rst && mw_flush_c;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (pc_stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      drain_cnt_q <= '0;
      stall_cnt_q <= '0;
      halt_q      <= 1'b0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      halt_q      <= halt_d;
      mem_err_q   <= mem_err_d;
    end
  end

  always_comb begin
    halt      = halt_q;
    mem_err   = mem_err_q;
    stall_cnt = stall_cnt_q;
  end

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Scoreboard bench for hazard_flush_ctrl: stimulus pushes hand-computed per-cycle
// expectations, a negedge monitor pops and compares them against the DUT outputs.
module tb_hazard_flush_ctrl;

  // Output vector order: {pc_stall, fd_stall, fd_flush, de_stall, de_flush, em_stall, em_flush, mw_flush}
  localparam logic [7:0] NONE = 8'b0000_0000;
  localparam logic [7:0] LU   = 8'b1100_1000;
  localparam logic [7:0] BR   = 8'b0010_1000;
  localparam logic [7:0] FRZ  = 8'b1101_0101;
  localparam logic [7:0] ECL  = 8'b1010_1010;
  localparam logic [7:0] HLT  = 8'b1010_1011;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1_index, id_rs2_index, ex_rd_index;
  logic        id_rs2_used, ex_wb_en, ex_wb_sel, ex_branch_taken;
  logic        mem_ecall_sig, mem_dm_req, mem_dm_ready;

  logic        pc_stall, fd_stall, fd_flush, de_stall, de_flush, em_stall, em_flush, mw_flush;
  logic        halt, mem_err;
  logic [15:0] stall_cnt;

  logic        s_pc_stall, s_fd_stall, s_fd_flush, s_de_stall, s_de_flush, s_em_stall, s_em_flush, s_mw_flush;
  logic        s_halt, s_mem_err;
  logic [2:0]  s_stall_cnt;

  typedef struct {
    logic [7:0] o;
    logic       h;
    logic       e;
    int         cnt;
    logic       ck;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_cnt  = 0;
  logic cnt_known = 1'b0;

  always #5 clk = ~clk;

  hazard_flush_ctrl #(.DRAIN_CYCLES(2), .MEM_TIMEOUT(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_index(id_rs1_index), .id_rs2_index(id_rs2_index), .id_rs2_used(id_rs2_used),
    .ex_rd_index(ex_rd_index), .ex_wb_en(ex_wb_en), .ex_wb_sel(ex_wb_sel),
    .ex_branch_taken(ex_branch_taken), .mem_ecall_sig(mem_ecall_sig),
    .mem_dm_req(mem_dm_req), .mem_dm_ready(mem_dm_ready),
    .pc_stall(pc_stall), .fd_stall(fd_stall), .fd_flush(fd_flush), .de_stall(de_stall),
    .de_flush(de_flush), .em_stall(em_stall), .em_flush(em_flush), .mw_flush(mw_flush),
    .halt(halt), .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  // Narrow counter instance exercises saturation within a short run.
  hazard_flush_ctrl #(.DRAIN_CYCLES(2), .MEM_TIMEOUT(4), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst),
    .id_rs1_index(id_rs1_index), .id_rs2_index(id_rs2_index), .id_rs2_used(id_rs2_used),
    .ex_rd_index(ex_rd_index), .ex_wb_en(ex_wb_en), .ex_wb_sel(ex_wb_sel),
    .ex_branch_taken(ex_branch_taken), .mem_ecall_sig(mem_ecall_sig),
    .mem_dm_req(mem_dm_req), .mem_dm_ready(mem_dm_ready),
    .pc_stall(s_pc_stall), .fd_stall(s_fd_stall), .fd_flush(s_fd_flush), .de_stall(s_de_stall),
    .de_flush(s_de_flush), .em_stall(s_em_stall), .em_flush(s_em_flush), .mw_flush(s_mw_flush),
    .halt(s_halt), .mem_err(s_mem_err), .stall_cnt(s_stall_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("ctrl_vec", 32'({pc_stall, fd_stall, fd_flush, de_stall, de_flush, em_stall, em_flush, mw_flush}),
            32'(x.o));
        chk("halt", 32'(halt), 32'(x.h));
        chk("mem_err", 32'(mem_err), 32'(x.e));
        chk("sat_ctrl_vec", 32'({s_pc_stall, s_fd_stall, s_fd_flush, s_de_stall, s_de_flush, s_em_stall,
                                 s_em_flush, s_mw_flush, s_halt, s_mem_err}), 32'({x.o, x.h, x.e}));
        if (x.ck) begin
          chk("stall_cnt", 32'(stall_cnt), 32'(x.cnt));
          chk("stall_cnt_sat", 32'(s_stall_cnt), (x.cnt > 7) ? 32'd7 : 32'(x.cnt));
        end
      end
    end
  end

  task automatic step(input logic [7:0] o, input logic h, input logic e);
    exp_t x;
    x.o = o; x.h = h; x.e = e; x.cnt = exp_cnt; x.ck = cnt_known;
    q.push_back(x);
    if (!rst) begin
      exp_cnt   = 0;
      cnt_known = 1'b1;
    end else if (o[7]) begin
      exp_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1_index = '0; id_rs2_index = '0; id_rs2_used = 1'b0; ex_rd_index = '0;
    ex_wb_en = 1'b0; ex_wb_sel = 1'b0; ex_branch_taken = 1'b0;
    mem_ecall_sig = 1'b0; mem_dm_req = 1'b0; mem_dm_ready = 1'b0;
  endtask

  task automatic load_in_e(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic used);
    ex_wb_en = 1'b1; ex_wb_sel = 1'b1; ex_rd_index = rd;
    id_rs1_index = rs1; id_rs2_index = rs2; id_rs2_used = used;
  endtask

  initial begin : stim
    idle();
    rst = 1'b0;
    @(posedge clk);
    #1;
    // Reset: outputs gated low even with active requests
    mem_ecall_sig = 1'b1; mem_dm_req = 1'b1; ex_branch_taken = 1'b1;
    step(NONE, 1'b0, 1'b0);
    idle();
    step(NONE, 1'b0, 1'b0);
    rst = 1'b1;
    step(NONE, 1'b0, 1'b0);

    // Load-use on rs1, one bubble then clear
    load_in_e(5'd5, 5'd5, 5'd0, 1'b0); step(LU, 1'b0, 1'b0);
    idle();                             step(NONE, 1'b0, 1'b0);
    load_in_e(5'd0, 5'd0, 5'd0, 1'b1); step(NONE, 1'b0, 1'b0);
    load_in_e(5'd7, 5'd1, 5'd7, 1'b1); step(LU, 1'b0, 1'b0);
    load_in_e(5'd7, 5'd1, 5'd7, 1'b0); step(NONE, 1'b0, 1'b0);
    load_in_e(5'd5, 5'd5, 5'd0, 1'b0); ex_wb_sel = 1'b0; step(NONE, 1'b0, 1'b0);
    load_in_e(5'd5, 5'd5, 5'd0, 1'b0); ex_wb_en = 1'b0;  step(NONE, 1'b0, 1'b0);

    // Branch overrides load-use, no PC stall
    load_in_e(5'd5, 5'd5, 5'd0, 1'b0); ex_branch_taken = 1'b1; step(BR, 1'b0, 1'b0);
    idle(); mem_dm_req = 1'b1; mem_dm_ready = 1'b1; step(NONE, 1'b0, 1'b0);

    // Memory wait: 4 frozen cycles, branch/load-use ignored while waiting
    idle(); mem_dm_req = 1'b1; step(FRZ, 1'b0, 1'b0);
    ex_branch_taken = 1'b1;             step(FRZ, 1'b0, 1'b0);
    load_in_e(5'd3, 5'd3, 5'd0, 1'b0); step(FRZ, 1'b0, 1'b0);
                                        step(FRZ, 1'b0, 1'b0);
    idle(); mem_dm_req = 1'b1; mem_dm_ready = 1'b1; step(NONE, 1'b0, 1'b0);
    idle();                             step(NONE, 1'b0, 1'b0);

    // Ecall beats a simultaneous memory wait, drains 2 cycles, halts sticky
    mem_ecall_sig = 1'b1; mem_dm_req = 1'b1; step(ECL, 1'b0, 1'b0);
    idle();                             step(ECL, 1'b0, 1'b0);
    mem_dm_req = 1'b1;                  step(ECL, 1'b0, 1'b0);
    idle();                             step(HLT, 1'b1, 1'b0);
    mem_dm_req = 1'b1; mem_dm_ready = 1'b1; step(HLT, 1'b1, 1'b0);
    idle(); rst = 1'b0;                 step(NONE, 1'b1, 1'b0);
    rst = 1'b1;                         step(NONE, 1'b0, 1'b0);

    // Reset mid-DRAIN returns to RUN
    mem_ecall_sig = 1'b1;               step(ECL, 1'b0, 1'b0);
    idle();                             step(ECL, 1'b0, 1'b0);
    rst = 1'b0;                         step(NONE, 1'b0, 1'b0);
    rst = 1'b1;                         step(NONE, 1'b0, 1'b0);
    load_in_e(5'd9, 5'd9, 5'd0, 1'b0); step(LU, 1'b0, 1'b0);
    idle();                             step(NONE, 1'b0, 1'b0);

    // Reset pulse with no clock edge leaves DRAIN untouched
    mem_ecall_sig = 1'b1;               step(ECL, 1'b0, 1'b0);
    idle(); rst = 1'b0; #2; rst = 1'b1; step(ECL, 1'b0, 1'b0);
                                        step(ECL, 1'b0, 1'b0);
                                        step(HLT, 1'b1, 1'b0);
    rst = 1'b0;                         step(NONE, 1'b1, 1'b0);
    rst = 1'b1;                         step(NONE, 1'b0, 1'b0);

    // Memory timeout: 5 frozen cycles, then HALT with mem_err; counter saturates
    mem_dm_req = 1'b1;
    for (int i = 0; i < 5; i++) step(FRZ, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      mem_dm_ready = (i % 2 == 1);
      step(HLT, 1'b1, 1'b1);
    end
    rst = 1'b0;                         step(NONE, 1'b1, 1'b1);
    idle(); rst = 1'b1;                 step(NONE, 1'b0, 1'b0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_queue: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
